// File: rtl/bus_op_pkg.sv
// Shared opcode type and the op-to-character helper used by bus_op_queue.
package bus_op_pkg;

  typedef enum logic [1:0] {
    OP_READ       = 2'd0,
    OP_WRITE      = 2'd1,
    OP_MODIFY     = 2'd2,
    OP_INVALIDATE = 2'd3
  } op_t;

  function automatic byte op_char(input op_t op);
    byte c;
    case (op)
      OP_READ:       c = "R";
      OP_WRITE:      c = "W";
      OP_MODIFY:     c = "M";
      OP_INVALIDATE: c = "I";
      default:       c = "?";
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requesting channel at or after rr_ptr (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant
);

  int   idx;
  logic found;

  // Scan channels starting at rr_ptr; grant only the first requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (enable) begin
      for (int off = 0; off < NUM_CH; off++) begin
        idx = (int'(rr_ptr) + off) % NUM_CH;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end else begin
          found = found;
        end
      end
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/bus_op_queue.sv
// Round-robin arbitrated FWFT queue of bus operations feeding a valid/ready bus.
// Optional macro BUS_OP_TRACE_EN enables a simulation-only enqueue/dequeue log.
module bus_op_queue
  import bus_op_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter int NUM_CH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [2*NUM_CH-1:0]        req_op,
  input  logic [ADDR_W*NUM_CH-1:0]   req_addr,
  output logic [NUM_CH-1:0]          req_ready,
  output logic                       bus_valid,
  output logic [1:0]                 bus_op,
  output logic [ADDR_W-1:0]          bus_addr,
  input  logic                       bus_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  op_t               mem_op   [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_next;
  logic [CH_W-1:0]   gnt_idx;
  logic [NUM_CH-1:0] grant;
  logic              full_int;
  logic              enq;
  logic              deq;
  op_t               enq_op;
  logic [ADDR_W-1:0] enq_addr;

  // full comes from the registered count only, keeping bus_ready off the req_ready path.
  assign full_int  = (count == CNT_W'(DEPTH));
  assign full      = full_int && !reset;
  assign empty     = (count == CNT_W'(0)) || reset;
  assign bus_valid = !empty;
  assign bus_op    = mem_op[rd_ptr];
  assign bus_addr  = mem_addr[rd_ptr];
  assign req_ready = grant;
  assign enq       = |(req_valid & grant);
  assign deq       = bus_valid && bus_ready;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .enable (!full_int && !reset),
    .grant  (grant)
  );

  // Select the granted channel's payload and the round-robin successor.
  always_comb begin
    gnt_idx  = '0;
    enq_op   = OP_READ;
    enq_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        gnt_idx  = CH_W'(i);
        enq_op   = op_t'(req_op[2*i +: 2]);
        enq_addr = req_addr[ADDR_W*i +: ADDR_W];
      end else begin
        gnt_idx = gnt_idx;
      end
    end
    if (gnt_idx == CH_W'(NUM_CH-1)) begin
      rr_next = '0;
    end else begin
      rr_next = gnt_idx + CH_W'(1);
    end
  end

  // Storage is never cleared; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_op[wr_ptr]   <= enq_op;
      mem_addr[wr_ptr] <= enq_addr;
    end
  end

  // Pointers, occupancy and round-robin state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr_ptr <= rr_next;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef BUS_OP_TRACE_EN
`ifndef SYNTHESIS
  // Simulation-only transaction log.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      $display("ENQ ch%0d %s %h", gnt_idx, op_char(enq_op), enq_addr);
    end
    if (!reset && deq) begin
      $display("%s %h", op_char(op_t'(bus_op)), bus_addr);
    end
  end
`endif
`else
`endif

endmodule

// File: tb/tb_bus_op_queue.sv
// Directed self-checking bench for bus_op_queue (ADDR_W=32, DEPTH=8, NUM_CH=2).
module tb_bus_op_queue;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;
  localparam int NUM_CH = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        req_valid;
  logic [2*NUM_CH-1:0]      req_op;
  logic [ADDR_W*NUM_CH-1:0] req_addr;
  logic [NUM_CH-1:0]        req_ready;
  logic                     bus_valid;
  logic [1:0]               bus_op;
  logic [ADDR_W-1:0]        bus_addr;
  logic                     bus_ready;
  logic [3:0]               count;
  logic                     full;
  logic                     empty;

  int checks   = 0;
  int failures = 0;

  bus_op_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .bus_valid (bus_valid),
    .bus_op    (bus_op),
    .bus_addr  (bus_addr),
    .bus_ready (bus_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    bus_ready = 1'b0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic [1:0] op, input logic [31:0] addr);
    req_op[2*ch +: 2]            = op;
    req_addr[ADDR_W*ch +: ADDR_W] = addr;
  endtask

  task automatic push(input int ch, input logic [1:0] op, input logic [31:0] addr);
    set_req(ch, op, addr);
    req_valid     = '0;
    req_valid[ch] = 1'b1;
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus_ready = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_valid = 2'b11;
    tick();
    tick();
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL reset_bus_valid got=%b exp=0", bus_valid); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    req_valid = '0;
    reset     = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus_ready = 1'b1;
    set_req(0, 2'd0, 32'h0000_1000);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus_valid); end
    checks++; if (bus_op !== 2'd0) begin failures++; $display("FAIL single_op got=%0d exp=0", bus_op); end
    checks++; if (bus_addr !== 32'h0000_1000) begin failures++; $display("FAIL single_addr got=%h exp=00001000", bus_addr); end
    tick();
    checks++; if (empty !== 1'b1 || bus_valid !== 1'b0) begin failures++; $display("FAIL single_drain got empty=%b valid=%b exp empty=1 valid=0", empty, bus_valid); end
  endtask

  task automatic test_fill();
    bus_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_req(0, 2'd1, 32'h100 + ((i < 8) ? i : 8));
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== ((i < 8) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL fill_ready_%0d got=%b exp=%b", i, req_ready, (i < 8) ? 2'b01 : 2'b00); end
      tick();
    end
    req_valid = '0;
    checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL fill_full got full=%b count=%0d exp full=1 count=8", full, count); end
    bus_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus_valid !== 1'b1 || bus_addr !== 32'h100 + i) begin failures++; $display("FAIL drain_%0d got valid=%b addr=%h exp valid=1 addr=%h", i, bus_valid, bus_addr, 32'h100 + i); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(0, 2'd0, 32'h200 + i);
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL refill_count got=%0d exp=5", count); end
    bus_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus_addr !== 32'h200 + i) begin failures++; $display("FAIL refill_drain_%0d got=%h exp=%h", i, bus_addr, 32'h200 + i); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL refill_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr;
    logic [1:0]  exp_op;
    do_reset();
    bus_ready = 1'b1;
    set_req(0, 2'd1, 32'h0000_A000);
    set_req(1, 2'd2, 32'h0000_B000);
    req_valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      exp_gnt  = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = ((c % 2 == 0) ? 32'h0000_A000 : 32'h0000_B000) + c / 2;
      exp_op   = (c % 2 == 0) ? 2'd1 : 2'd2;
      #1;
      checks++; if (req_ready !== exp_gnt) begin failures++; $display("FAIL fair_grant_%0d got=%b exp=%b", c, req_ready, exp_gnt); end
      tick();
      checks++; if (bus_valid !== 1'b1 || bus_addr !== exp_addr || bus_op !== exp_op) begin failures++; $display("FAIL fair_bus_%0d got addr=%h op=%0d exp addr=%h op=%0d", c, bus_addr, bus_op, exp_addr, exp_op); end
      if (c % 2 == 0) set_req(0, 2'd1, 32'h0000_A000 + c / 2 + 1);
      else            set_req(1, 2'd2, 32'h0000_B000 + c / 2 + 1);
    end
    req_valid = '0;
    tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fair_empty got=%b exp=1", empty); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) push(0, 2'd0, 32'h300 + i);
    set_req(0, 2'd0, 32'h303);
    req_valid = 2'b01;
    bus_ready = 1'b1;
    tick();
    req_valid = '0;
    bus_ready = 1'b0;
    checks++; if (count !== 4'd3 || bus_addr !== 32'h301) begin failures++; $display("FAIL simul_both got count=%0d head=%h exp count=3 head=00000301", count, bus_addr); end
    for (int i = 4; i < 9; i++) push(0, 2'd0, 32'h300 + i);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL simul_full got=%b exp=1", full); end
    set_req(0, 2'd0, 32'h309);
    req_valid = 2'b01;
    bus_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL simul_full_ready got=%b exp=00", req_ready); end
    tick();
    req_valid = '0;
    bus_ready = 1'b0;
    checks++; if (count !== 4'd7 || bus_addr !== 32'h302) begin failures++; $display("FAIL simul_full_deq got count=%0d head=%h exp count=7 head=00000302", count, bus_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) push(0, 2'd1, 32'h400 + i);
    reset = 1'b1;
    #1;
    checks++; if (bus_valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL midrst_during got valid=%b empty=%b exp valid=0 empty=1", bus_valid, empty); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || bus_valid !== 1'b0) begin failures++; $display("FAIL midrst_after got count=%0d empty=%b valid=%b exp 0 1 0", count, empty, bus_valid); end
    push(1, 2'd3, 32'h500);
    checks++; if (bus_valid !== 1'b1 || bus_addr !== 32'h500 || bus_op !== 2'd3) begin failures++; $display("FAIL midrst_next got valid=%b addr=%h op=%0d exp 1 00000500 3", bus_valid, bus_addr, bus_op); end
  endtask

  task automatic test_opcodes();
    logic [31:0] exp_addr;
    do_reset();
    push(0, 2'd1, 32'hA0);
    push(0, 2'd2, 32'hB0);
    push(0, 2'd3, 32'hC0);
    bus_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'hA0 + 32'h10 * i;
      checks++; if (bus_op !== 2'(i + 1) || bus_addr !== exp_addr) begin failures++; $display("FAIL opcode_%0d got op=%0d addr=%h exp op=%0d addr=%h", i, bus_op, bus_addr, i + 1, exp_addr); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL opcode_empty got=%b exp=1", empty); end
    bus_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_fairness();
    test_simultaneous();
    test_reset_mid();
    test_opcodes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
